// File: rtl/muldiv_ctrl.sv
// Shared controller for one iterative unsigned multiply/divide unit: round-robin
// arbitration, operand sign stripping, RISC-V special cases and result sign fix-up.
module muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*3-1:0]      req_op_i,
  input  logic [NREQ*XLEN-1:0]   req_a_i,
  input  logic [NREQ*XLEN-1:0]   req_b_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0]        flush_i,
  output logic [NREQ-1:0]        rsp_valid_o,
  output logic [XLEN-1:0]        rsp_data_o,
  output logic                   unit_start_o,
  output logic                   unit_is_div_o,
  output logic [XLEN-1:0]        unit_a_o,
  output logic [XLEN-1:0]        unit_b_o,
  input  logic                   unit_busy_i,
  input  logic                   unit_done_i,
  input  logic [2*XLEN-1:0]      unit_prod_i,
  input  logic [XLEN-1:0]        unit_quo_i,
  input  logic [XLEN-1:0]        unit_rem_i,
  output logic [2:0]             dbg_state_o
);
  // Handshake: requester k offers an op by holding req_valid_i[k]; the op is taken
  // in the cycle req_ready_o[k] pulses. The result comes back in the single cycle
  // rsp_valid_o[k] is high, with rsp_data_o valid alongside; there is no back-pressure.

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   owner_q;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic            grant;
  logic            flush_own;

  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            sel_sa, sel_sb;
  logic            sel_special;
  logic [XLEN-1:0] special_res;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Round-robin search starting at rr_ptr; lowest offset wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr_q) + i) % NREQ);
      if (req_valid_i[cand] && !flush_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == grant_idx) begin
        sel_op = req_op_i[k*3 +: 3];
        sel_a  = req_a_i[k*XLEN +: XLEN];
        sel_b  = req_b_i[k*XLEN +: XLEN];
      end
    end
  end

  assign sel_sa = sel_a[XLEN-1] &
                  (sel_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sel_sb = sel_b[XLEN-1] & (sel_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});

  // Divide-by-zero and signed overflow never reach the unit.
  always_comb begin
    sel_special = 1'b0;
    special_res = '0;
    if (sel_op[2] && sel_b == '0) begin
      sel_special = 1'b1;
      special_res = sel_op[1] ? sel_a : '1;
    end else if ((sel_op == OP_DIV || sel_op == OP_REM) && sel_a == MIN_NEG && sel_b == '1) begin
      sel_special = 1'b1;
      special_res = (sel_op == OP_DIV) ? MIN_NEG : '0;
    end
  end

  assign prod_fix = (sa_q ^ sb_q) ? -unit_prod_i : unit_prod_i;
  assign quo_fix  = (sa_q ^ sb_q) ? -unit_quo_i : unit_quo_i;
  assign rem_fix  = sa_q ? -unit_rem_i : unit_rem_i;

  always_comb begin
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  assign grant     = (state_q == S_IDLE) && grant_found;
  assign flush_own = flush_i[owner_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = sel_special ? S_RESP : S_ISSUE;
      S_ISSUE: begin
        if (unit_busy_i) state_d = flush_own ? S_IDLE : S_ISSUE;
        else             state_d = flush_own ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush_own)        state_d = unit_done_i ? S_IDLE : S_DRAIN;
        else if (unit_done_i) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (unit_done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    unit_start_o = 1'b0;
    if (!rst_i) begin
      if (grant) req_ready_o = ONE_HOT0 << grant_idx;
      if (state_q == S_RESP && !flush_own) rsp_valid_o = ONE_HOT0 << owner_q;
      if (state_q == S_ISSUE && !unit_busy_i) unit_start_o = 1'b1;
    end
  end

  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      op_q          <= '0;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      unit_is_div_o <= 1'b0;
      unit_a_o      <= '0;
      unit_b_o      <= '0;
      rsp_data_o    <= '0;
    end else if (grant) begin
      rr_ptr_q      <= IW'((int'(grant_idx) + 1) % NREQ);
      owner_q       <= grant_idx;
      op_q          <= sel_op;
      sa_q          <= sel_sa;
      sb_q          <= sel_sb;
      unit_is_div_o <= sel_op[2];
      unit_a_o      <= sel_sa ? -sel_a : sel_a;
      unit_b_o      <= sel_sb ? -sel_b : sel_b;
      if (sel_special) rsp_data_o <= special_res;
    end else if (state_q == S_WAIT && unit_done_i && !flush_own) begin
      rsp_data_o <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a fixed-latency unsigned multiply/divide unit stub.
module tb_muldiv_ctrl;
  localparam int XLEN = 32;
  localparam int NREQ = 2;
  localparam int STUB_LAT = 4;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic                 clk_i, rst_i;
  logic [NREQ-1:0]      req_valid_i, req_ready_o, flush_i, rsp_valid_o;
  logic [NREQ*3-1:0]    req_op_i;
  logic [NREQ*XLEN-1:0] req_a_i, req_b_i;
  logic [XLEN-1:0]      rsp_data_o, unit_a_o, unit_b_o, unit_quo_i, unit_rem_i;
  logic                 unit_start_o, unit_is_div_o, unit_busy_i, unit_done_i;
  logic [2*XLEN-1:0]    unit_prod_i;
  logic [2:0]           dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [NREQ-1:0] own_q[$];

  muldiv_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .unit_start_o(unit_start_o), .unit_is_div_o(unit_is_div_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_busy_i(unit_busy_i), .unit_done_i(unit_done_i),
    .unit_prod_i(unit_prod_i), .unit_quo_i(unit_quo_i), .unit_rem_i(unit_rem_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Unit stub: done pulses STUB_LAT cycles after the start pulse.
  logic            stub_active, force_busy;
  int              stub_cnt;
  logic [XLEN-1:0] stub_a, stub_b;

  assign unit_busy_i = stub_active | force_busy;
  assign unit_prod_i = {32'd0, stub_a} * {32'd0, stub_b};
  assign unit_quo_i  = (stub_b == 0) ? '1 : stub_a / stub_b;
  assign unit_rem_i  = (stub_b == 0) ? stub_a : stub_a % stub_b;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
      unit_done_i <= 1'b0;
      stub_a      <= '0;
      stub_b      <= '0;
    end else begin
      unit_done_i <= 1'b0;
      if (stub_active) begin
        if (stub_cnt == 1) begin
          unit_done_i <= 1'b1;
          stub_active <= 1'b0;
        end
        stub_cnt <= stub_cnt - 1;
      end else if (unit_start_o) begin
        stub_active <= 1'b1;
        stub_cnt    <= STUB_LAT - 1;
        stub_a      <= unit_a_o;
        stub_b      <= unit_b_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: offer one op at cycle T, then watch up to 40 cycles for start and response.
  task automatic run_op(input int k, input logic [2:0] op, input logic [XLEN-1:0] a, b,
                        output logic [NREQ-1:0] rdy, output int start_cyc, output int rsp_cyc,
                        output logic [XLEN-1:0] data, output logic [NREQ-1:0] rspv,
                        output logic [XLEN-1:0] ua, output logic [XLEN-1:0] ub);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    req_valid_i[k] = 1'b1;
    req_op_i[k*3 +: 3] = op;
    req_a_i[k*XLEN +: XLEN] = a;
    req_b_i[k*XLEN +: XLEN] = b;
    #1;
    rdy = req_ready_o;
    start_cyc = -1; rsp_cyc = -1; data = '0; rspv = '0; ua = '0; ub = '0;
    @(posedge clk_i); #1;
    req_valid_i = '0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (c == 1) begin ua = unit_a_o; ub = unit_b_o; end
      if (unit_start_o && start_cyc < 0) start_cyc = c;
      if (rsp_valid_o != '0) begin
        rsp_cyc = c; data = rsp_data_o; rspv = rsp_valid_o;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 2'b01; req_op_i = '0; req_a_i = 64'h1; req_b_i = 64'h1;
    @(posedge clk_i); #2;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data_o); end
    checks++; if (unit_start_o !== 1'b0 || unit_is_div_o !== 1'b0) begin errors++; $display("FAIL reset_unit_ctl got=%b%b exp=00", unit_start_o, unit_is_div_o); end
    checks++; if (unit_a_o !== 32'h0 || unit_b_o !== 32'h0) begin errors++; $display("FAIL reset_unit_ops got=%h/%h exp=0/0", unit_a_o, unit_b_o); end
    checks++; if (dbg_state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    req_valid_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_mul_sign();
    logic [NREQ-1:0] rdy, rspv; int sc, rc; logic [XLEN-1:0] d, ua, ub;
    run_op(0, OP_MULH, 32'hFFFFFFFD, 32'd7, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL mulh_ready got=%b exp=01", rdy); end
    checks++; if (ua !== 32'd3 || ub !== 32'd7) begin errors++; $display("FAIL mulh_operands got=%h/%h exp=3/7", ua, ub); end
    checks++; if (sc !== 1) begin errors++; $display("FAIL mulh_start_cycle got=%0d exp=1", sc); end
    checks++; if (rc !== 6) begin errors++; $display("FAIL mulh_rsp_cycle got=%0d exp=6", rc); end
    checks++; if (d !== 32'hFFFFFFFF || rspv !== 2'b01) begin errors++; $display("FAIL mulh_data got=%h/%b exp=ffffffff/01", d, rspv); end
    run_op(1, OP_MUL, 32'hFFFFFFFD, 32'd7, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (d !== 32'hFFFFFFEB || rspv !== 2'b10) begin errors++; $display("FAIL mul_data got=%h/%b exp=ffffffeb/10", d, rspv); end
    run_op(0, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (ua !== 32'd1 || ub !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_operands got=%h/%h exp=1/ffffffff", ua, ub); end
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_data got=%h exp=ffffffff", d); end
  endtask

  task automatic test_special();
    logic [NREQ-1:0] rdy, rspv; int sc, rc; logic [XLEN-1:0] d, ua, ub;
    run_op(0, OP_DIV, 32'd5, 32'd0, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (sc !== -1) begin errors++; $display("FAIL div0_no_start got=%0d exp=-1", sc); end
    checks++; if (rc !== 1 || d !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0 got=%0d/%h exp=1/ffffffff", rc, d); end
    run_op(1, OP_REM, 32'd5, 32'd0, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (rc !== 1 || d !== 32'd5 || rspv !== 2'b10) begin errors++; $display("FAIL rem0 got=%0d/%h/%b exp=1/5/10", rc, d, rspv); end
    run_op(0, OP_DIVU, 32'd5, 32'd0, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (rc !== 1 || d !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0 got=%0d/%h exp=1/ffffffff", rc, d); end
    run_op(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (rc !== 1 || sc !== -1 || d !== 32'h80000000) begin errors++; $display("FAIL div_ovf got=%0d/%0d/%h exp=1/-1/80000000", rc, sc, d); end
    run_op(1, OP_REM, 32'h80000000, 32'hFFFFFFFF, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (rc !== 1 || d !== 32'h0) begin errors++; $display("FAIL rem_ovf got=%0d/%h exp=1/0", rc, d); end
  endtask

  task automatic test_signed_div();
    logic [NREQ-1:0] rdy, rspv; int sc, rc; logic [XLEN-1:0] d, ua, ub;
    run_op(0, OP_REM, 32'hFFFFFFF9, 32'd2, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (ua !== 32'd7 || ub !== 32'd2) begin errors++; $display("FAIL rem_operands got=%h/%h exp=7/2", ua, ub); end
    checks++; if (rc !== 6 || d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg got=%0d/%h exp=6/ffffffff", rc, d); end
    run_op(1, OP_DIV, 32'hFFFFFFF9, 32'd2, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (d !== 32'hFFFFFFFD || rspv !== 2'b10) begin errors++; $display("FAIL div_neg got=%h/%b exp=fffffffd/10", d, rspv); end
    run_op(0, OP_REMU, 32'hFFFFFFF9, 32'd2, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL remu got=%h exp=1", d); end
  endtask

  task automatic test_round_robin();
    logic [XLEN-1:0] a0 [4] = '{32'd3, 32'd5, 32'd7, 32'd9};
    logic [XLEN-1:0] e0 [4] = '{32'd33, 32'd55, 32'd77, 32'd99};
    logic [XLEN-1:0] a1 [4] = '{32'h111, 32'h222, 32'h333, 32'h444};
    int sent [2];
    int got, last_k, k;
    logic [XLEN-1:0] ed;
    logic [NREQ-1:0] eo;
    sent[0] = 0; sent[1] = 0; got = 0; last_k = -1;
    for (int c = 0; c < 300 && got < 8; c++) begin
      @(posedge clk_i); #1;
      req_valid_i[0] = (sent[0] < 4);
      req_valid_i[1] = (sent[1] < 4);
      req_op_i = {OP_REMU, OP_MUL};
      req_a_i[31:0]  = (sent[0] < 4) ? a0[sent[0]] : 32'd0;
      req_b_i[31:0]  = 32'd11;
      req_a_i[63:32] = (sent[1] < 4) ? a1[sent[1]] : 32'd0;
      req_b_i[63:32] = 32'd0;
      #1;
      if (rsp_valid_o != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rr_unexpected_rsp got=%b/%h exp=none", rsp_valid_o, rsp_data_o);
        end else begin
          ed = exp_q.pop_front();
          eo = own_q.pop_front();
          if (rsp_valid_o !== eo || rsp_data_o !== ed) begin
            errors++; $display("FAIL rr_rsp got=%b/%h exp=%b/%h", rsp_valid_o, rsp_data_o, eo, ed);
          end
        end
        got++;
      end
      if (req_ready_o != '0) begin
        k = req_ready_o[1] ? 1 : 0;
        if (last_k >= 0) begin
          checks++;
          if (k == last_k) begin errors++; $display("FAIL rr_alternate got=%0d exp=%0d", k, 1 - last_k); end
        end
        last_k = k;
        own_q.push_back(req_ready_o);
        exp_q.push_back(k == 1 ? a1[sent[1]] : e0[sent[0]]);
        sent[k]++;
      end
    end
    req_valid_i = '0;
    checks++; if (got !== 8) begin errors++; $display("FAIL rr_complete got=%0d exp=8", got); end
  endtask

  task automatic test_flush_wait();
    int gc; logic seen_rsp;
    @(posedge clk_i); #1;
    req_valid_i = 2'b01; req_op_i[2:0] = OP_MULHU; req_a_i[31:0] = 32'd5; req_b_i[31:0] = 32'd6;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL fw_ready got=%b exp=01", req_ready_o); end
    @(posedge clk_i); #1; req_valid_i = '0;
    @(posedge clk_i); #1; flush_i = 2'b01;
    @(posedge clk_i); #1; flush_i = '0;
    req_valid_i = 2'b10; req_op_i[5:3] = OP_DIV; req_a_i[63:32] = 32'd5; req_b_i[63:32] = 32'd0;
    #1;
    checks++; if (dbg_state_o !== 3'd4) begin errors++; $display("FAIL fw_drain_state got=%0d exp=4", dbg_state_o); end
    gc = -1; seen_rsp = 1'b0;
    for (int c = 3; c < 20; c++) begin
      if (c > 3) #1;
      if (rsp_valid_o != '0) seen_rsp = 1'b1;
      if (req_ready_o != '0) begin gc = c; break; end
      @(posedge clk_i); #1;
    end
    checks++; if (gc !== 6) begin errors++; $display("FAIL fw_next_grant_cycle got=%0d exp=6", gc); end
    checks++; if (seen_rsp !== 1'b0) begin errors++; $display("FAIL fw_flushed_rsp got=1 exp=0"); end
    @(posedge clk_i); #1; req_valid_i = '0;
    #1;
    checks++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL fw_after got=%b/%h exp=10/ffffffff", rsp_valid_o, rsp_data_o); end
  endtask

  task automatic test_flush_issue();
    int seen;
    force_busy = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 2'b01; req_op_i[2:0] = OP_MUL; req_a_i[31:0] = 32'd2; req_b_i[31:0] = 32'd3;
    @(posedge clk_i); #1; req_valid_i = '0;
    #1;
    checks++; if (unit_start_o !== 1'b0 || dbg_state_o !== 3'd1) begin errors++; $display("FAIL fi_stall got=%b/%0d exp=0/1", unit_start_o, dbg_state_o); end
    @(posedge clk_i); #1; flush_i = 2'b01;
    @(posedge clk_i); #1; flush_i = '0; force_busy = 1'b0;
    #1;
    checks++; if (dbg_state_o !== 3'd0) begin errors++; $display("FAIL fi_idle got=%0d exp=0", dbg_state_o); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (unit_start_o || rsp_valid_o != '0) seen++;
      @(posedge clk_i); #2;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL fi_no_activity got=%0d exp=0", seen); end
    #3;
    req_valid_i = 2'b01; flush_i = 2'b01; req_op_i[2:0] = OP_DIV; req_b_i[31:0] = 32'd0;
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL fi_mask_ready got=%b exp=00", req_ready_o); end
    @(posedge clk_i); #1; req_valid_i = '0; flush_i = '0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] rdy, rspv; int sc, rc; logic [XLEN-1:0] d, ua, ub;
    @(posedge clk_i); #1;
    req_valid_i = 2'b01; req_op_i[2:0] = OP_DIVU; req_a_i[31:0] = 32'hFFFFFFFF; req_b_i[31:0] = 32'd2;
    @(posedge clk_i); #1; req_valid_i = '0;
    @(posedge clk_i); #2;
    checks++; if (dbg_state_o !== 3'd2 || unit_is_div_o !== 1'b1) begin errors++; $display("FAIL rm_wait got=%0d/%b exp=2/1", dbg_state_o, unit_is_div_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (unit_a_o !== 32'h0 || unit_b_o !== 32'h0 || unit_is_div_o !== 1'b0) begin errors++; $display("FAIL rm_unit got=%h/%h/%b exp=0/0/0", unit_a_o, unit_b_o, unit_is_div_o); end
    checks++; if (rsp_data_o !== 32'h0 || dbg_state_o !== 3'd0 || unit_start_o !== 1'b0 || rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rm_outputs got=%h/%0d/%b/%b exp=0/0/0/00", rsp_data_o, dbg_state_o, unit_start_o, rsp_valid_o); end
    @(posedge clk_i); #1; rst_i = 1'b0;
    run_op(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, rdy, sc, rc, d, rspv, ua, ub);
    checks++; if (rdy !== 2'b01 || rc !== 6 || d !== 32'hFFFFFFFE) begin errors++; $display("FAIL rm_mulhu got=%b/%0d/%h exp=01/6/fffffffe", rdy, rc, d); end
  endtask

  initial begin
    rst_i = 1'b1; force_busy = 1'b0;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0; flush_i = '0;
    test_reset();
    test_mul_sign();
    test_special();
    test_signed_div();
    test_round_robin();
    test_flush_wait();
    test_flush_issue();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
